// File: rtl/ahb3lite_mem_slave_if.sv
// AHB3-Lite bus bundle between a single master (through decoder/mux) and the
// memory slave. Clock and reset stay outside as plain ports.
interface ahb3lite_mem_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HREADYOUT;
    logic        HREADY;
    logic        HRESP;

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
        input  HRDATA, HREADYOUT, HRESP, HREADY
    );
endinterface

// File: rtl/ahb3lite_mem_slave.sv
// AHB3-Lite word-addressed RAM slave: zero-wait OKAY, two-cycle ERROR.
// Optional wait states per legal transfer when AHB_SLV_WAIT_EN is defined.
module ahb3lite_mem_slave #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb3lite_mem_slave_if.slave  bus
);

    localparam int          IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) * 33'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
`ifdef AHB_SLV_WAIT_EN
        ST_ERR2,
        ST_WAIT
`else
        ST_ERR2
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W+1:0] addr_q, addr_d;
    logic             write_q, write_d;
    logic [2:0]       size_q, size_d;
    logic [31:0]      mem_q [MEM_DEPTH];

`ifdef AHB_SLV_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
    localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

    logic             accept;
    logic             addr_err;
    logic             commit;
    logic [3:0]       byte_en;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      hrdata;
    logic             hreadyout;
    logic             hresp;
    logic             unused_ok;

    // Burst type and protection carry no meaning for a plain RAM.
    assign unused_ok = ^{bus.HBURST, bus.HPROT};

    assign accept   = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign word_idx = addr_q[IDX_W+1:2];

    always_comb begin
        addr_err = 1'b0;
        if (bus.HSIZE > 3'd2)                               addr_err = 1'b1;
        if (bus.HSIZE == 3'd1 && bus.HADDR[0])              addr_err = 1'b1;
        if (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00)   addr_err = 1'b1;
        if ({1'b0, bus.HADDR} >= MEM_BYTES)                 addr_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
`ifdef AHB_SLV_WAIT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            ST_ERR1: state_d = ST_ERR2;
`ifdef AHB_SLV_WAIT_EN
            ST_WAIT: begin
                if (wait_cnt_q == CNT_W'(WAIT_CYCLES - 1)) state_d = ST_DATA;
                else                                       wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
`endif
            default: begin
                // IDLE, DATA and ERR2 all end with HREADY high, so a new
                // address phase may be taken straight into the next data phase.
                state_d = ST_IDLE;
                if (accept) begin
                    addr_d  = bus.HADDR[IDX_W+1:0];
                    write_d = bus.HWRITE;
                    size_d  = bus.HSIZE;
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else begin
`ifdef AHB_SLV_WAIT_EN
                        if (WAIT_CYCLES > 0) begin
                            state_d    = ST_WAIT;
                            wait_cnt_d = '0;
                        end else begin
                            state_d = ST_DATA;
                        end
`else
                        state_d = ST_DATA;
`endif
                    end
                end
            end
        endcase
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        commit    = 1'b0;
        case (state_q)
            ST_DATA: begin
                if (write_q) commit = 1'b1;
                else         hrdata = mem_q[word_idx];
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            ST_ERR2: hresp = 1'b1;
`ifdef AHB_SLV_WAIT_EN
            ST_WAIT: hreadyout = 1'b0;
`endif
            default: ;
        endcase
    end

    // Little-endian lane select from the registered size and low address bits.
    always_comb begin
        case (size_q)
            3'd0:    byte_en = 4'b0001 << addr_q[1:0];
            3'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    assign bus.HRDATA    = hrdata;
    assign bus.HREADYOUT = hreadyout;
    assign bus.HRESP     = hresp;

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
`ifdef AHB_SLV_WAIT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
`ifdef AHB_SLV_WAIT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    // Memory is never cleared; reset only suppresses the pending write.
    always_ff @(posedge HCLK) begin
        if (!HRESETn && commit) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
// Bench for ahb3lite_mem_slave: transfer-level reference model of the RAM and
// the OKAY/ERROR/wait timing, driven by directed and random AHB traffic.
module tb_ahb3lite_mem_slave;

    localparam int MEM_DEPTH   = 256;
    localparam int WAIT_CYCLES = 1;
`ifdef AHB_SLV_WAIT_EN
    localparam int W = WAIT_CYCLES;
`else
    localparam int W = 0;
`endif

    typedef struct packed {
        logic [1:0]  trans;
        logic        sel;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct packed {
        logic        rdy;
        logic        resp;
        logic [31:0] rdata;
    } obs_t;

    logic HCLK;
    logic HRESETn;
    ahb3lite_mem_slave_if bus ();

    assign bus.HREADY = bus.HREADYOUT;

    ahb3lite_mem_slave #(.MEM_DEPTH(MEM_DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [MEM_DEPTH];
    xfer_t       seq_q[$];
    obs_t        act_q[$];
    obs_t        exp_q[$];
    logic [31:0] rd_q[$];

    function automatic xfer_t xf(logic [1:0] t, logic s, logic w, logic [2:0] sz,
                                 logic [31:0] a, logic [31:0] d);
        xfer_t x;
        x.trans = t; x.sel = s; x.write = w; x.size = sz; x.addr = a; x.wdata = d;
        return x;
    endfunction

    function automatic bit legal(xfer_t x);
        longint unsigned n;
        n = longint'(1) << x.size;
        if (x.size > 3'd2) return 1'b0;
        if ((longint'(x.addr) % n) != 0) return 1'b0;
        return longint'(x.addr) < longint'(MEM_DEPTH) * 4;
    endfunction

    task automatic apply_write(xfer_t x);
        int idx, off, n;
        idx = int'(x.addr >> 2);
        off = int'(x.addr[1:0]);
        n   = 1 << x.size;
        for (int b = off; b < off + n; b++) ref_mem[idx][8*b +: 8] = x.wdata[8*b +: 8];
    endtask

    task automatic drive(xfer_t x);
        bus.HSEL   = x.sel;
        bus.HTRANS = x.trans;
        bus.HWRITE = x.write;
        bus.HSIZE  = x.size;
        bus.HADDR  = x.addr;
        bus.HBURST = 3'($urandom_range(0, 7));
        bus.HPROT  = 4'($urandom_range(0, 15));
    endtask

    // Plays seq_q on the bus (entered and left at a falling edge), logging the
    // observed and modelled outputs of every cycle plus the read data seen.
    task automatic run_seq();
        xfer_t dp, cur;
        bit    dp_v, dp_ok;
        int    ph, budget, idx;
        obs_t  a, e;
        act_q.delete(); exp_q.delete(); rd_q.delete();
        dp_v = 0; dp_ok = 0; ph = 0; dp = '0;
        budget = (W + 3) * seq_q.size() + 16;
        while ((seq_q.size() > 0 || dp_v) && budget > 0) begin
            e = '{rdy: 1'b1, resp: 1'b0, rdata: 32'h0};
            if (dp_v) begin
                if (!dp_ok) begin
                    e.rdy  = (ph == 1);
                    e.resp = 1'b1;
                end else begin
                    e.rdy = (ph == W);
                    if (e.rdy && !dp.write) begin
                        idx     = int'(dp.addr >> 2);
                        e.rdata = ref_mem[idx];
                    end
                end
            end
            a = '{rdy: bus.HREADYOUT, resp: bus.HRESP, rdata: bus.HRDATA};
            act_q.push_back(a);
            exp_q.push_back(e);
            bus.HWDATA = (dp_v && dp.write) ? dp.wdata : $urandom();
            if (dp_v && e.rdy) begin
                if (dp_ok && dp.write) apply_write(dp);
                if (dp_ok && !dp.write) rd_q.push_back(bus.HRDATA);
                dp_v = 0;
            end else if (dp_v) begin
                ph++;
            end
            if (e.rdy) begin
                cur = (seq_q.size() > 0) ? seq_q.pop_front() : xf(2'b00, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
                drive(cur);
                if (cur.sel && cur.trans[1]) begin
                    dp = cur; dp_v = 1; dp_ok = legal(cur); ph = 0;
                end
            end
            @(negedge HCLK);
            budget--;
        end
        drive(xf(2'b00, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0));
        checks++;
        if (seq_q.size() > 0 || dp_v) begin
            errors++;
            $display("FAIL run_seq timeout: %0d transfers left, data phase pending=%0d", seq_q.size(), dp_v);
            seq_q.delete();
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b1;
        bus.HWDATA = 32'h0;
        drive(xf(2'b00, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0));
        repeat (2) @(negedge HCLK);
        checks++; if (bus.HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b want 1", bus.HREADYOUT); end
        checks++; if (bus.HRESP !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b want 0", bus.HRESP); end
        checks++; if (bus.HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", bus.HRDATA); end
        HRESETn = 1'b0;
        @(negedge HCLK);
        checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got rdy=%b resp=%b want 1/0", bus.HREADYOUT, bus.HRESP);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < MEM_DEPTH; i++)
            seq_q.push_back(xf(2'b10, 1'b1, 1'b1, 3'd2, 32'(i * 4), $urandom()));
        run_seq();
        for (int i = 0; i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL fill cyc %0d: got rdy=%b resp=%b rdata=%h want rdy=%b resp=%b rdata=%h",
                         i, act_q[i].rdy, act_q[i].resp, act_q[i].rdata, exp_q[i].rdy, exp_q[i].resp, exp_q[i].rdata);
            end
        end
    endtask

    task automatic test_word_rw();
        seq_q.push_back(xf(2'b10, 1'b1, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF));
        seq_q.push_back(xf(2'b10, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0));
        run_seq();
        for (int i = 0; i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL word_rw cyc %0d: got rdy=%b resp=%b rdata=%h want rdy=%b resp=%b rdata=%h",
                         i, act_q[i].rdy, act_q[i].resp, act_q[i].rdata, exp_q[i].rdy, exp_q[i].resp, exp_q[i].rdata);
            end
        end
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL word_rw_data: got %h (%0d reads) want deadbeef", (rd_q.size() > 0) ? rd_q[0] : 32'h0, rd_q.size());
        end
    endtask

    task automatic test_lanes();
        seq_q.push_back(xf(2'b10, 1'b1, 1'b1, 3'd2, 32'h20, 32'h00000000));
        seq_q.push_back(xf(2'b10, 1'b1, 1'b1, 3'd0, 32'h21, 32'h0000AA00));
        seq_q.push_back(xf(2'b10, 1'b1, 1'b1, 3'd1, 32'h22, 32'h55550000));
        seq_q.push_back(xf(2'b10, 1'b1, 1'b0, 3'd2, 32'h20, 32'h0));
        run_seq();
        for (int i = 0; i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL lanes cyc %0d: got rdy=%b resp=%b rdata=%h want rdy=%b resp=%b rdata=%h",
                         i, act_q[i].rdy, act_q[i].resp, act_q[i].rdata, exp_q[i].rdy, exp_q[i].resp, exp_q[i].rdata);
            end
        end
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== 32'h5555AA00) begin
            errors++; $display("FAIL lanes_data: got %h want 5555aa00", (rd_q.size() > 0) ? rd_q[0] : 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        seq_q.push_back(xf(2'b10, 1'b1, 1'b1, 3'd2, 32'h0, 32'h11111111));
        seq_q.push_back(xf(2'b11, 1'b1, 1'b1, 3'd2, 32'h4, 32'h22222222));
        seq_q.push_back(xf(2'b11, 1'b1, 1'b0, 3'd2, 32'h0, 32'h0));
        seq_q.push_back(xf(2'b11, 1'b1, 1'b0, 3'd2, 32'h4, 32'h0));
        run_seq();
        for (int i = 0; i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b cyc %0d: got rdy=%b resp=%b rdata=%h want rdy=%b resp=%b rdata=%h",
                         i, act_q[i].rdy, act_q[i].resp, act_q[i].rdata, exp_q[i].rdy, exp_q[i].resp, exp_q[i].rdata);
            end
        end
        checks++;
        if (rd_q.size() != 2 || rd_q[0] !== 32'h11111111 || rd_q[1] !== 32'h22222222) begin
            errors++; $display("FAIL b2b_data: got %0d reads first=%h want 11111111 then 22222222",
                               rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'h0);
        end
        checks++;
        if (act_q.size() != 4 * (W + 1) + 1) begin
            errors++; $display("FAIL b2b_cycles: got %0d want %0d", act_q.size(), 4 * (W + 1) + 1);
        end
    endtask

    task automatic test_errors();
        logic [31:0] pre0, pre30, pre40;
        int          n_err1;
        pre0 = ref_mem[0]; pre30 = ref_mem[12]; pre40 = ref_mem[16];
        seq_q.push_back(xf(2'b10, 1'b1, 1'b1, 3'd2, 32'h02, 32'hCAFEF00D));
        seq_q.push_back(xf(2'b10, 1'b1, 1'b0, 3'd2, 32'h400, 32'h0));
        seq_q.push_back(xf(2'b10, 1'b1, 1'b1, 3'd3, 32'h30, 32'h12345678));
        seq_q.push_back(xf(2'b10, 1'b1, 1'b1, 3'd1, 32'h41, 32'hABCDABCD));
        seq_q.push_back(xf(2'b10, 1'b1, 1'b0, 3'd2, 32'h00, 32'h0));
        seq_q.push_back(xf(2'b10, 1'b1, 1'b0, 3'd2, 32'h30, 32'h0));
        seq_q.push_back(xf(2'b10, 1'b1, 1'b0, 3'd2, 32'h40, 32'h0));
        run_seq();
        n_err1 = 0;
        for (int i = 0; i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL errors cyc %0d: got rdy=%b resp=%b rdata=%h want rdy=%b resp=%b rdata=%h",
                         i, act_q[i].rdy, act_q[i].resp, act_q[i].rdata, exp_q[i].rdy, exp_q[i].resp, exp_q[i].rdata);
            end
            if (act_q[i].rdy === 1'b0 && act_q[i].resp === 1'b1) n_err1++;
        end
        checks++;
        if (n_err1 != 4) begin errors++; $display("FAIL err1_count: got %0d want 4", n_err1); end
        checks++;
        if (rd_q.size() != 3 || rd_q[0] !== pre0 || rd_q[1] !== pre30 || rd_q[2] !== pre40) begin
            errors++; $display("FAIL errors_mem_unchanged: got %0d reads first=%h want %h", rd_q.size(),
                               (rd_q.size() > 0) ? rd_q[0] : 32'h0, pre0);
        end
    endtask

    task automatic test_idle_busy_unsel();
        logic [31:0] pre [4];
        for (int i = 0; i < 4; i++) pre[i] = ref_mem[20 + i];
        seq_q.push_back(xf(2'b00, 1'b1, 1'b1, 3'd2, 32'h50, 32'hFFFFFFFF));
        seq_q.push_back(xf(2'b01, 1'b1, 1'b1, 3'd2, 32'h54, 32'hFFFFFFFF));
        seq_q.push_back(xf(2'b10, 1'b0, 1'b1, 3'd2, 32'h58, 32'hFFFFFFFF));
        seq_q.push_back(xf(2'b11, 1'b0, 1'b1, 3'd2, 32'h5C, 32'hFFFFFFFF));
        for (int i = 0; i < 4; i++) seq_q.push_back(xf(2'b10, 1'b1, 1'b0, 3'd2, 32'(32'h50 + i * 4), 32'h0));
        run_seq();
        for (int i = 0; i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL idle_busy cyc %0d: got rdy=%b resp=%b rdata=%h want rdy=%b resp=%b rdata=%h",
                         i, act_q[i].rdy, act_q[i].resp, act_q[i].rdata, exp_q[i].rdy, exp_q[i].resp, exp_q[i].rdata);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_q.size() != 4 || rd_q[i] !== pre[i]) begin
                errors++; $display("FAIL idle_busy_mem word %0d: got %h want %h", i, (rd_q.size() == 4) ? rd_q[i] : 32'h0, pre[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] pre;
        pre = ref_mem[16];
        drive(xf(2'b10, 1'b1, 1'b1, 3'd2, 32'h40, 32'h0));
        @(negedge HCLK);
        checks++;
        if (bus.HREADYOUT !== (W == 0)) begin errors++; $display("FAIL reset_mid_dphase: got rdy=%b", bus.HREADYOUT); end
        bus.HWDATA = ~pre;
        HRESETn = 1'b1;
        drive(xf(2'b00, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0));
        @(negedge HCLK);
        checks++;
        if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 32'h0) begin
            errors++; $display("FAIL reset_mid_outputs: got rdy=%b resp=%b rdata=%h want 1 0 0", bus.HREADYOUT, bus.HRESP, bus.HRDATA);
        end
        HRESETn = 1'b0;
        seq_q.push_back(xf(2'b10, 1'b1, 1'b0, 3'd2, 32'h40, 32'h0));
        run_seq();
        for (int i = 0; i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_mid cyc %0d: got rdy=%b resp=%b rdata=%h want rdy=%b resp=%b rdata=%h",
                         i, act_q[i].rdy, act_q[i].resp, act_q[i].rdata, exp_q[i].rdy, exp_q[i].resp, exp_q[i].rdata);
            end
        end
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== pre) begin
            errors++; $display("FAIL reset_mid_discard: got %h want %h", (rd_q.size() > 0) ? rd_q[0] : 32'h0, pre);
        end
    endtask

    task automatic test_random();
        xfer_t       x;
        logic [2:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 300; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) a = 32'(MEM_DEPTH * 4 + $urandom_range(0, 255));
            else                           a = 32'($urandom_range(0, MEM_DEPTH * 4 - 1));
            if (sz <= 3'd2 && $urandom_range(0, 9) < 8) a = a & ~((32'd1 << sz) - 32'd1);
            x = xf(($urandom_range(0, 9) < 8) ? {1'b1, 1'($urandom_range(0, 1))} : {1'b0, 1'($urandom_range(0, 1))},
                   ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), sz, a, $urandom());
            seq_q.push_back(x);
        end
        for (int i = 0; i < MEM_DEPTH; i++) seq_q.push_back(xf(2'b11, 1'b1, 1'b0, 3'd2, 32'(i * 4), 32'h0));
        run_seq();
        for (int i = 0; i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random cyc %0d: got rdy=%b resp=%b rdata=%h want rdy=%b resp=%b rdata=%h",
                         i, act_q[i].rdy, act_q[i].resp, act_q[i].rdata, exp_q[i].rdy, exp_q[i].resp, exp_q[i].rdata);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_word_rw();
        test_lanes();
        test_back_to_back();
        test_errors();
        test_idle_busy_unsel();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb3lite_mem_slave.md
Name: ahb3lite_mem_slave

Overview:
- AHB3-Lite (single-master) memory slave: word-addressed on-chip RAM behind a standard AHB-Lite slave interface.
- Zero-wait OKAY responses for legal transfers; two-cycle ERROR response for illegal ones.
- Sits on the AHB-Lite bus behind the decoder (HSEL) and the response mux (HREADY fed back to HREADY input).

Parameters:
- MEM_DEPTH, 256, number of 32-bit words; legal byte addresses 0 .. MEM_DEPTH*4-1.
- WAIT_CYCLES, 1, wait states per transfer; used only when AHB_SLV_WAIT_EN is defined.

Ports:
- HCLK  input  1  bus clock; all state updates on rising edge.
- HRESETn  input  1  reset, synchronous, active-high (asserted = 1, despite the name).
- HSEL  input  1  slave select from decoder.
- HADDR  input  32  byte address (address phase).
- HWDATA  input  32  write data (data phase).
- HRDATA  output  32  read data (data phase).
- HWRITE  input  1  1 = write, 0 = read.
- HSIZE  input  3  0 = byte, 1 = halfword, 2 = word.
- HBURST  input  3  burst type; accepted, no functional effect.
- HPROT  input  4  protection; accepted, ignored.
- HTRANS  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- HREADYOUT  output  1  slave ready.
- HREADY  input  1  bus-level ready (previous transfer complete).
- HRESP  output  1  0 OKAY, 1 ERROR.

Behaviour:
- Address phase accepted on a rising edge where HSEL & HREADY & HTRANS[1]. On acceptance, register HADDR, HWRITE, HSIZE and the error flag; the next cycle is the data phase.
- IDLE/BUSY, or HSEL=0: no data phase; HREADYOUT=1, HRESP=0.
- Error flag is set when any of these holds:
  - HSIZE>2.
  - Halfword with HADDR[0]=1.
  - Word with HADDR[1:0]!=0.
  - HADDR >= MEM_DEPTH*4.
- State machine:
  - IDLE: no pending data phase.
  - DATA: OKAY data phase.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions:
  - Accepted legal transfer -> DATA.
  - Accepted illegal transfer -> ERR1 -> ERR2.
  - From DATA or ERR2, a new accepted transfer goes straight to the next DATA/ERR1; otherwise -> IDLE.
  - In ERR1, HREADY is low, so no address is accepted.
- Write:
  - Performed at the end of an OKAY data phase: mem[addr_q[31:2]] updated on byte lanes selected by HSIZE/addr_q[1:0], little-endian.
  - Byte: lane addr_q[1:0]. Halfword: lanes {addr_q[1],0}+{0,1}. Word: all four.
  - Unselected lanes are unchanged. Writes are suppressed on ERROR.
- Read:
  - HRDATA = mem[addr_q[31:2]] (full word, combinational from registered address) during a read DATA phase; 0 otherwise.
  - Back-to-back write then read of the same word returns the new data, because the write commits before the read's data phase.
- Timing: zero wait states for OKAY transfers; throughput one transfer per cycle; bursts are treated as independent single transfers.
- Reset (HRESETn=1 at clock edge):
  - State -> IDLE; HREADYOUT=1, HRESP=0, HRDATA=0.
  - Any pending write is discarded.
  - Memory contents are not cleared.
  - Reset mid-transfer aborts the transfer.

Optional Feature:
- Macro: AHB_SLV_WAIT_EN.
- Defined: every legal accepted transfer first spends WAIT_CYCLES cycles with HREADYOUT=0, HRESP=0, then completes with HREADYOUT=1. The write commits and read data is valid only in that final cycle. ERROR transfers skip the wait states.
- Undefined: zero-wait operation as above; WAIT_CYCLES is unused.

Test Plan:
- Reset: HRESETn=1 for 2 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0.
- Word write then read: write 0xDEADBEEF to 0x10, then read 0x10 -> HRDATA=0xDEADBEEF. Both transfers have HREADYOUT=1, HRESP=0.
- Byte/halfword lanes: word-write 0x00000000 to 0x20, byte-write 0xAA to 0x21, halfword-write 0x5555 to 0x22 -> word read at 0x20 = 0x5555AA00.
- Pipelined back-to-back: NONSEQ write 0x11111111 to 0x0, SEQ write 0x22222222 to 0x4, SEQ reads of 0x0 and 0x4 with no idle cycles -> reads return 0x11111111 and 0x22222222.
- Errors: each of these gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), and the target memory is unchanged:
  - Word write to 0x02 (misaligned).
  - Read at 0x400 with MEM_DEPTH=256 (out of range).
  - HSIZE=3.
- IDLE/BUSY and HSEL=0 traffic with HWRITE=1 -> memory unchanged, HRESP=0. With AHB_SLV_WAIT_EN and WAIT_CYCLES=1 -> each legal transfer shows exactly one HREADYOUT=0 cycle.
